nes_controller_sim: RTL and testbench
=====================================

Name:
nes_controller_sim

Overview:
- Behavioural and synthesizable model of a standard NES joypad, built as a 4021-style 8-bit parallel-in/serial-out shift register.
- Sits on the CPU-clock side of the console bench, in place of a physical controller.
- The console drives `strobe` (latch) and `rd` (one pulse per CPU read of $4016).
- The model returns one button bit per read on `data`.

Parameters:
- NUM_BTNS, 8: width of the button vector and shift register.
- FILL_BIT, 1'b1: value shifted into the MSB on each shift. Reads after the 8th return this value.
- INVERT_DATA, 0: when 1, `data` is the complement of the shift-register LSB (electrical active-low pad). When 0, pressed reads as 1.

Ports:
- clk  input  1  CPU-rate clock. All state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- strobe  input  1  latch control. While high, the register continuously reloads from `btns`.
- rd  input  1  read strobe. Asserted (one or more cycles) for each CPU read of the port.
- btns  input  NUM_BTNS  live button state, 1 = pressed.
  - Bit order: 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right.
- data  output  1  serial button bit currently presented to the CPU.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- State:
  - `shreg[NUM_BTNS-1:0]`
  - `rd_q` (registered `rd`, for edge detection)
- Reset values: `shreg` = 0, `rd_q` = 0. Hence `data` = 0 (or 1 if INVERT_DATA). Reset has immediate effect, mid-sequence included.
- Output: `data` = `shreg[0]` (XOR INVERT_DATA), purely combinational from state.
  - The bit is stable for the whole `rd` assertion.
  - Zero latency: the current bit is visible during the first cycle of `rd`.
- Load: any clk edge with `strobe` = 1 gives `shreg <= btns`.
  - While `strobe` is held, `data` tracks `btns[0]` with one clk of latency.
  - `rd` pulses during `strobe` high do not shift.
- Shift: occurs at a clk edge where `strobe` = 0 and (`rd_q` = 1, `rd` = 0), i.e. a falling edge of `rd`.
  - Action: `shreg <= {FILL_BIT, shreg[NUM_BTNS-1:1]}`.
  - Exactly one shift per read pulse, regardless of pulse length.
- `rd_q <= rd` every cycle.
- Priority: a load beats a shift in the same cycle. A `strobe` rise mid-sequence restarts at bit A.
- `strobe` falling edge: the register keeps the value captured on the last strobe-high edge. Button changes after that are ignored until the next strobe.
- Wrap: no counter. After NUM_BTNS shifts the register holds all FILL_BIT, so `data` = FILL_BIT indefinitely, with no wrap back to A.
- A `rd` pulse spanning a `strobe` edge is evaluated per the rules above at each edge. No other state exists.

Decomposition:
- Shared package `nes_ctrl_pkg` holds:
  - BTN_A = 0, BTN_B = 1, BTN_SELECT = 2, BTN_START = 3, BTN_UP = 4, BTN_DOWN = 5, BTN_LEFT = 6, BTN_RIGHT = 7
  - NUM_BTNS default 8
  - typedef `btn_vec_t` as logic[7:0]
- Single module. No sub-module is warranted; the edge detector is inline.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle with `shreg` nonzero → `data` = 0 immediately; `shreg` = 0 after release.
- Select-only read:
  - Setup: `btns` = 8'b00000100; `strobe` high 2 clks then low; 8 single-cycle `rd` pulses.
  - Required `data` sampled during each `rd`: 0,0,1,0,0,0,0,0.
  - Ninth and tenth reads → 1,1.
- Long `rd`: `btns` = 8'h01; strobe; `rd` held 3 clks per read → `data` = 1 then 0. Exactly one shift per pulse; the 2nd read returns B = 0.
- Strobe dominance:
  - `rd` pulses while `strobe` = 1 with `btns` = 8'h81 → `data` stays 1, no shift.
  - Change `btns` to 8'h80 while `strobe` = 1 → `data` becomes 0 after one clk.
- Mid-sequence restart: `btns` = 8'h05; strobe; 2 reads (1,0); strobe again; read → 1 (A again), then 0, 1.
- Latch hold: `btns` = 8'h01; strobe low; change `btns` to 8'h00 before reading → first read still returns 1.

Source files
------------

// File: rtl/nes_controller_sim_pkg.sv
// Shared constants and types for the NES joypad model: button bit
// positions within the latched vector and the default pad width.
package nes_ctrl_pkg;

    // Standard NES pad bit order; bit 0 is shifted out first.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NUM_BTNS = 8;

    typedef logic [7:0] btn_vec_t;

endpackage

// File: rtl/nes_controller_sim.sv
// NES joypad model: 4021-style parallel-in/serial-out shift register.
// strobe high continuously reloads the register from the live buttons;
// each falling edge of rd (with strobe low) shifts one bit toward data,
// backfilling with FILL_BIT so reads past the last button return FILL_BIT.
module nes_controller_sim #(
    parameter int   NUM_BTNS    = nes_ctrl_pkg::NUM_BTNS,
    parameter logic FILL_BIT    = 1'b1,
    parameter logic INVERT_DATA = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic                rd,
    input  logic [NUM_BTNS-1:0] btns,
    output logic                data
);

    import nes_ctrl_pkg::*;

    logic [NUM_BTNS-1:0] shreg;
    logic                rd_q;
    logic                shift_en;

    // A read completes on the falling edge of rd, so a long rd pulse still
    // advances the register exactly once and the bit stays put while rd is high.
    assign shift_en = rd_q & ~rd;

    // Load dominates shift; reset is asynchronous so it clears mid-sequence.
    // NOTE: non-blocking assignments here so every register samples pre-edge
    // values; blocking would let rd_q update before shift_en is evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            rd_q  <= 1'b0;
        end else begin
            rd_q <= rd;
            if (strobe) begin
                shreg <= btns;
            end else if (shift_en) begin
                shreg <= {FILL_BIT, shreg[NUM_BTNS-1:1]};
            end
        end
    end

    // Current bit is purely combinational from state: visible in rd's first cycle.
    assign data = shreg[BTN_A] ^ INVERT_DATA;

endmodule

// File: tb/tb_nes_controller_sim.sv
// Directed self-checking bench for nes_controller_sim (default parameters).
// Inputs change 1 ns after each rising clock edge; data is sampled there too,
// well away from the next active edge.
module tb_nes_controller_sim;

    logic       clk;
    logic       rst;
    logic       strobe;
    logic       rd;
    logic [7:0] btns;
    logic       data;

    int n_checks = 0;
    int n_fail   = 0;

    nes_controller_sim dut (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .rd     (rd),
        .btns   (btns),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latch the given buttons: strobe high for two edges, then low.
    task automatic latch(input logic [7:0] b);
        btns   = b;
        strobe = 1'b1;
        step();
        step();
        strobe = 1'b0;
    endtask

    // One CPU read: rd held for 'len' cycles. data must show the expected bit
    // from the first rd cycle and stay there while rd is high.
    task automatic do_read(input string tag, input int len, input logic exp);
        rd = 1'b1;
        check(tag, data, exp);
        for (int c = 0; c < len; c++) begin
            step();
            if (c < len - 1) check({tag, "_hold"}, data, exp);
        end
        rd = 1'b0;
        step();
    endtask

    logic [9:0] exp_sel;
    logic [2:0] exp_rst;

    initial begin
        rst    = 1'b1;
        strobe = 1'b0;
        rd     = 1'b0;
        btns   = 8'h00;
        #12;
        check("reset_state", data, 1'b0);
        rst = 1'b0;
        step();
        check("post_reset", data, 1'b0);

        // Asynchronous reset mid-cycle with a nonzero register.
        latch(8'hFF);
        check("rst_preload", data, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", data, 1'b0);
        #1;
        rst = 1'b0;
        step();
        check("rst_released", data, 1'b0);

        // Select only: A..Right then two fill reads.
        exp_sel = 10'b11_0000_0100;
        latch(8'b0000_0100);
        for (int i = 0; i < 10; i++) begin
            do_read($sformatf("sel_rd%0d", i), 1, exp_sel[i]);
        end

        // Long rd pulses shift exactly once each.
        latch(8'h01);
        do_read("long_rd0", 3, 1'b1);
        do_read("long_rd1", 3, 1'b0);
        do_read("long_rd2", 3, 1'b0);

        // Strobe dominance: rd pulses while strobe high do not shift.
        btns   = 8'h81;
        strobe = 1'b1;
        step();
        step();
        check("strb_load", data, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rd = 1'b1;
            step();
            rd = 1'b0;
            step();
            check($sformatf("strb_rd%0d", i), data, 1'b1);
        end
        btns = 8'h80;
        check("strb_before_edge", data, 1'b1);
        step();
        check("strb_track", data, 1'b0);
        strobe = 1'b0;
        step();

        // Mid-sequence restart goes back to A.
        latch(8'h05);
        do_read("rst_seq0", 1, 1'b1);
        do_read("rst_seq1", 1, 1'b0);
        latch(8'h05);
        exp_rst = 3'b101;
        for (int i = 0; i < 3; i++) begin
            do_read($sformatf("restart%0d", i), 1, exp_rst[i]);
        end

        // Latch hold: button changes after strobe falls are ignored.
        latch(8'h01);
        step();
        btns = 8'h00;
        step();
        do_read("hold_rd0", 1, 1'b1);
        do_read("hold_rd1", 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
